// File: rtl/box_draw_sequencer.sv
// Tile-draw request queue feeding dynamicBox: 4-deep {tile,colour} FIFO plus a box-command FSM.
// Optional flash-then-restore second pass is enabled by defining FLASH_RESTORE_EN.
module box_draw_sequencer #(
  parameter logic [7:0]  TILE_W       = 8'd70,
  parameter logic [6:0]  TILE_H       = 7'd50,
  parameter logic [7:0]  X0           = 8'd8,
  parameter logic [7:0]  X1           = 8'd82,
  parameter logic [6:0]  Y0           = 7'd8,
  parameter logic [6:0]  Y1           = 7'd62,
  parameter logic [15:0] PLOT_CYCLES  = 16'd3623,
  parameter logic [24:0] FLASH_CYCLES = 25'd25000000,
  parameter logic [2:0]  BASE_COLOUR  = 3'b000
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic       iReq,
  input  logic [1:0] iTile,
  input  logic [2:0] iColour,
  output logic       oFull,
  output logic       oBusy,
  output logic       oDone,
  output logic       oOverflow,
  output logic [7:0] oXCoord,
  output logic [6:0] oYCoord,
  output logic [7:0] oXSize,
  output logic [6:0] oYSize,
  output logic [2:0] oColour,
  output logic       oPlot
);

`ifdef FLASH_RESTORE_EN
  localparam int unsigned CW = 25;
  typedef enum logic [2:0] {IDLE, LOAD, PLOT, GAP, HOLD, RESTORE} state_t;
  localparam logic [CW-1:0] FLASH_LAST = FLASH_CYCLES - 25'd1;
`else
  localparam int unsigned CW = 16;
  typedef enum logic [2:0] {IDLE, LOAD, PLOT, GAP} state_t;
`endif

  localparam logic [CW-1:0] PLOT_LAST = CW'(PLOT_CYCLES) - CW'(1);

  state_t        state_q, state_d;
  logic [4:0]    mem_q [4];
  logic [4:0]    mem_d [4];
  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    x_q, x_d, xs_q, xs_d;
  logic [6:0]    y_q, y_d, ys_q, ys_d;
  logic [2:0]    col_q, col_d;
  logic          plot_q, plot_d;
  logic          done_q, done_d;
  logic          second_q, second_d;
  logic          push, pop;
  logic [4:0]    head;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    xs_d     = xs_q;
    ys_d     = ys_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    second_d = second_q;

    // A request arriving while full is dropped even if this edge also pops.
    push = iReq && (count_q != 3'd4);
    pop  = (state_q == IDLE) && (count_q != 3'd0);
    head = mem_q[rd_ptr_q];

    if (iReq && (count_q == 3'd4)) ovf_d = 1'b1;
    if (push) begin
      mem_d[wr_ptr_q] = {iTile, iColour};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, push} - {2'b00, pop};

    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d  = LOAD;
          x_d      = head[3] ? X1 : X0;
          y_d      = head[4] ? Y1 : Y0;
          xs_d     = TILE_W;
          ys_d     = TILE_H;
          col_d    = head[2:0];
          second_d = 1'b0;
        end
      end
      LOAD: begin
        state_d = PLOT;
        plot_d  = 1'b1;
        cnt_d   = '0;
      end
      PLOT: begin
        if (cnt_q == PLOT_LAST) begin
          cnt_d = '0;
`ifdef FLASH_RESTORE_EN
          if (!second_q) begin
            state_d = HOLD;
          end else begin
            state_d = GAP;
            done_d  = 1'b1;
          end
`else
          state_d = GAP;
          done_d  = 1'b1;
`endif
        end else begin
          cnt_d  = cnt_q + CW'(1);
          plot_d = 1'b1;
        end
      end
      GAP: state_d = IDLE;
`ifdef FLASH_RESTORE_EN
      HOLD: begin
        if (cnt_q == FLASH_LAST) begin
          cnt_d   = '0;
          state_d = RESTORE;
          col_d   = BASE_COLOUR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESTORE: begin
        state_d  = PLOT;
        plot_d   = 1'b1;
        second_d = 1'b1;
        cnt_d    = '0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q  <= IDLE;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      col_q    <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      second_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xs_q     <= xs_d;
      ys_q     <= ys_d;
      col_q    <= col_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      second_q <= second_d;
    end
  end

  assign oFull     = (count_q == 3'd4);
  assign oBusy     = (state_q != IDLE) || (count_q != 3'd0);
  assign oDone     = done_q;
  assign oOverflow = ovf_q;
  assign oXCoord   = x_q;
  assign oYCoord   = y_q;
  assign oXSize    = xs_q;
  assign oYSize    = ys_q;
  assign oColour   = col_q;
  assign oPlot     = plot_q;

endmodule

// File: tb/tb_box_draw_sequencer.sv
// Self-checking bench for box_draw_sequencer: directed scenarios plus randomized request bursts
// compared against a queue-based model of draws, windows and done pulses.
module tb_box_draw_sequencer;

  localparam int PLEN = 14;
  localparam int HLEN = 5;
`ifdef FLASH_RESTORE_EN
  localparam int NWIN = 2;
`else
  localparam int NWIN = 1;
`endif

  logic       iClock = 1'b0;
  logic       iResetn = 1'b0;
  logic       iReq = 1'b0;
  logic [1:0] iTile = '0;
  logic [2:0] iColour = '0;
  logic       oFull, oBusy, oDone, oOverflow, oPlot;
  logic [7:0] oXCoord, oXSize;
  logic [6:0] oYCoord, oYSize;
  logic [2:0] oColour;

  always #5 iClock = ~iClock;

  box_draw_sequencer #(
    .TILE_W(8'd3), .TILE_H(7'd2), .PLOT_CYCLES(16'd14), .FLASH_CYCLES(25'd5)
  ) dut (
    .iClock(iClock), .iResetn(iResetn), .iReq(iReq), .iTile(iTile), .iColour(iColour),
    .oFull(oFull), .oBusy(oBusy), .oDone(oDone), .oOverflow(oOverflow),
    .oXCoord(oXCoord), .oYCoord(oYCoord), .oXSize(oXSize), .oYSize(oYSize),
    .oColour(oColour), .oPlot(oPlot)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Observed plot windows and done pulses, recorded on the falling edge.
  typedef struct { int x; int y; int xs; int ys; int col; int len; int low; int unst; } win_t;
  win_t win_q[$];
  int   done_win_q[$];
  int   done_lag_q[$];
  int   wide_done = 0;
  win_t cur;
  int   hi_len = 0;
  int   low_len = 1000;
  bit   prev_plot = 0;
  bit   prev_done = 0;

  always @(negedge iClock) begin
    if (!iResetn) begin
      prev_plot = 0;
      prev_done = 0;
      low_len   = 1000;
    end else begin
      if (oPlot && !prev_plot) begin
        cur.x = oXCoord; cur.y = oYCoord; cur.xs = oXSize; cur.ys = oYSize;
        cur.col = oColour; cur.low = low_len; cur.unst = 0;
        hi_len = 1;
      end else if (oPlot) begin
        hi_len++;
        if (cur.x != oXCoord || cur.y != oYCoord || cur.xs != oXSize ||
            cur.ys != oYSize || cur.col != oColour) cur.unst = 1;
      end else if (prev_plot) begin
        cur.len = hi_len;
        win_q.push_back(cur);
        low_len = 1;
      end else if (low_len < 1000) begin
        low_len++;
      end
      if (oDone) begin
        done_win_q.push_back(win_q.size());
        done_lag_q.push_back(low_len);
        if (prev_done) wide_done++;
      end
      prev_plot = oPlot;
      prev_done = oDone;
    end
  end

  typedef struct { int tile; int col; } ent_t;
  ent_t model_q[$];
  int   rd_w = 0;
  int   rd_d = 0;
  bit   exp_ovf = 0;

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic drain();
    int   n, base_w, c;
    ent_t e;
    win_t wr;
    n = model_q.size();
    base_w = rd_w;
    c = 0;
    while (oBusy && c < 4000) begin step(); c++; end
    check("drain_busy", oBusy, 0);
    step(); step();
    for (int i = 0; i < n; i++) begin
      e = model_q[i];
      for (int w = 0; w < NWIN; w++) begin
        check("win_present", win_q.size() > rd_w, 1);
        if (win_q.size() <= rd_w) begin
          model_q.delete();
          return;
        end
        wr = win_q[rd_w];
        rd_w++;
        check("x_coord", wr.x, (e.tile % 2) ? 82 : 8);
        check("y_coord", wr.y, (e.tile / 2) ? 62 : 8);
        check("x_size", wr.xs, 3);
        check("y_size", wr.ys, 2);
        check("colour", wr.col, (w == 0) ? e.col : 0);
        check("plot_len", wr.len, PLEN);
        check("stable", wr.unst, 0);
        if (i > 0 || w > 0) check("low_gap", wr.low, (w == 1) ? HLEN + 1 : 3);
      end
    end
    check("done_count", done_win_q.size() - rd_d, n);
    for (int i = 0; i < n; i++) begin
      if (rd_d < done_win_q.size()) begin
        check("done_order", done_win_q[rd_d], base_w + (i + 1) * NWIN);
        check("done_lag", done_lag_q[rd_d], 1);
        rd_d++;
      end
    end
    rd_d = done_win_q.size();
    check("done_width", wide_done, 0);
    model_q.delete();
  endtask

  task automatic push_model(input int t, input int c);
    ent_t e;
    e.tile = t;
    e.col = c;
    model_q.push_back(e);
  endtask

  initial begin
    int n, t, c, nw, nd;

    // Reset with a request held active.
    iResetn = 0; iReq = 1; iTile = 2'd3; iColour = 3'd7;
    repeat (3) step();
    check("rst_coords", {2'b00, oXCoord, oYCoord, oXSize, oYSize}, 0);
    check("rst_flags", {oFull, oDone, oOverflow, oColour, oPlot}, 0);
    check("rst_busy", oBusy, 0);
    iReq = 0;
    step();
    iResetn = 1;
    repeat (3) step();
    check("idle_busy", oBusy, 0);

    // Single request: latency and command contents.
    iTile = 2'd3; iColour = 3'b100; iReq = 1;
    push_model(3, 4);
    step();
    iReq = 0;
    check("lat_n_plot", oPlot, 0);
    check("lat_n_busy", oBusy, 1);
    step();
    check("lat_n1_plot", oPlot, 0);
    step();
    check("lat_n2_plot", oPlot, 1);
    check("lat_x", oXCoord, 82);
    check("lat_y", oYCoord, 62);
    check("lat_xs", oXSize, 3);
    check("lat_ys", oYSize, 2);
    check("lat_col", oColour, 4);
    drain();

    // Six back-to-back requests: one in service, four queued, sixth dropped.
    for (int k = 0; k < 6; k++) begin
      iTile = 2'(k % 4);
      c = $urandom_range(0, 7);
      iColour = 3'(c);
      iReq = 1;
      if (k < 5) push_model(k % 4, c);
      step();
    end
    iReq = 0;
    exp_ovf = 1;
    check("burst6_full", oFull, 1);
    check("burst6_ovf", oOverflow, 1);
    drain();
    check("ovf_sticky", oOverflow, 1);

    // Randomized bursts starting from idle.
    repeat (6) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        t = $urandom_range(0, 3);
        c = $urandom_range(0, 7);
        iTile = 2'(t); iColour = 3'(c); iReq = 1;
        if (k < 5) push_model(t, c);
        step();
      end
      iReq = 0;
      check("rnd_full", oFull, n >= 5);
      check("rnd_ovf", oOverflow, exp_ovf);
      check("rnd_busy", oBusy, 1);
      drain();
    end

`ifdef FLASH_RESTORE_EN
    iTile = 2'd1; iColour = 3'b010; iReq = 1;
    push_model(1, 2);
    step();
    iReq = 0;
    drain();
`endif

    // Reset in the middle of a draw with two entries queued.
    for (int k = 0; k < 3; k++) begin
      iTile = 2'($urandom_range(0, 3)); iColour = 3'($urandom_range(0, 7)); iReq = 1;
      step();
    end
    iReq = 0;
    c = 0;
    while (!oPlot && c < 50) begin step(); c++; end
    check("abort_rise", oPlot, 1);
    repeat (6) step();
    #2 iResetn = 0;
    #1;
    check("abort_plot", oPlot, 0);
    check("abort_busy", oBusy, 0);
    check("abort_full", oFull, 0);
    check("abort_ovf", oOverflow, 0);
    check("abort_done", oDone, 0);
    nw = win_q.size();
    nd = done_win_q.size();
    repeat (2) step();
    iResetn = 1;
    repeat (40) step();
    check("abort_no_win", win_q.size(), nw);
    check("abort_no_done", done_win_q.size(), nd);
    check("abort_idle", oBusy, 0);

    // Recovery after the aborted draw.
    iTile = 2'd2; iColour = 3'b011; iReq = 1;
    push_model(2, 3);
    step();
    iReq = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
